func_rom_reader: RTL and testbench

Address sequencer and output buffer wrapped around the 16×5 function ROM. On a start pulse it walks the ROM over an inclusive address range, capturing each word into a small FIFO. Captured words go to the downstream consumer over a valid/ready handshake, and the block keeps a running sum of everything read. It sits directly upstream of the ROM, driving its address, and directly downstream of it, consuming its data.

---
 rtl/func_rom_reader.sv | 166 ++++++++++++++++
 tb/tb_func_rom_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/func_rom_reader.sv
`default_nettype none
// ============================================================================
// Module  : func_rom_reader
// Purpose : Scans an inclusive address range of the 16x5 function ROM into a
//           small FIFO and hands words downstream over valid/ready.
//           Optional running sum of read words: FUNC_ROM_READER_SUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module func_rom_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        first_addr,
    input  logic [ADDR_W-1:0]        last_addr,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W+ADDR_W-1:0] sum
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int SUM_W = DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]  end_q, end_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    logic               push, pop, full, empty;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        end_d      = end_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        done_d     = 1'b0;
        push       = 1'b0;
        full       = (count_q == CNT_W'(DEPTH));
        empty      = (count_q == '0);
        pop        = !empty && out_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rom_addr_d = first_addr;
                    end_d      = last_addr;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                // A pop frees a slot this same edge, so a full FIFO still
                // accepts a push when the head is being taken.
                if (!full || pop) begin
                    push = 1'b1;
                    if (rom_addr_q == end_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (count_q == CNT_W'(1))) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {rom_addr_q, rom_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            end_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            end_q      <= end_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            mem_q      <= mem_d;
        end
    end

`ifdef FUNC_ROM_READER_SUM_EN
    logic [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if ((state_q == S_IDLE) && start) begin
            sum_d = '0;
        end else if (push) begin
            sum_d = sum_q + SUM_W'(rom_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`else
    assign sum = '0;
`endif

    assign rom_addr  = rom_addr_q;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q][DATA_W-1:0];
    assign out_addr  = mem_q[rd_ptr_q][ENT_W-1:DATA_W];
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_func_rom_reader.sv
`default_nettype none
// Testbench for func_rom_reader: scoreboard of expected {addr,data} words
// filled at scan start and drained by a monitor as the DUT hands words out.
module tb_func_rom_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] first_addr;
    logic [3:0] last_addr;
    logic [3:0] rom_addr;
    logic [4:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic [3:0] out_addr;
    logic       busy;
    logic       done;
    logic [8:0] sum;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_w;
    logic [8:0] exp_sum;

    always #5 clk = ~clk;

    function automatic logic [4:0] rom_f(input logic [3:0] a);
        return {a, a[3]};
    endfunction

    assign rom_data = rom_f(rom_addr);

    func_rom_reader #(.ADDR_W(4), .DATA_W(5), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done),
        .sum        (sum)
    );

    // Monitor: every accepted handshake pops and compares the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got addr=%0d data=%0d, expected no word",
                         out_addr, out_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({out_addr, out_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL word_order: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             out_addr, out_data, exp_w[8:5], exp_w[4:0]);
                end
            end
        end
        if (rst_n && done) done_cnt++;
    end

    function automatic logic [8:0] sum_expect();
`ifdef FUNC_ROM_READER_SUM_EN
        return exp_sum;
`else
        return 9'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse and loads the scoreboard with the expected scan.
    task automatic start_scan(input logic [3:0] f, input logic [3:0] l);
        int         n;
        logic [3:0] a;
        n       = int'(4'(l - f)) + 1;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            a = f + 4'(i);
            exp_q.push_back({a, rom_f(a)});
            exp_sum = exp_sum + 9'(rom_f(a));
        end
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        repeat (3) tick();
        n_checks += 5;
        if (rom_addr !== 4'd0)  begin n_fail++; $display("FAIL rst_rom_addr: got %0d, expected 0", rom_addr); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b, expected 0", out_valid); end
        if ({out_addr, out_data} !== 9'd0) begin n_fail++; $display("FAIL rst_out_word: got %0h, expected 0", {out_addr, out_data}); end
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rst_busy_done: got %b, expected 00", {busy, done}); end
        if (sum !== 9'd0)       begin n_fail++; $display("FAIL rst_sum: got %0d, expected 0", sum); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int d0, cyc;
        d0        = done_cnt;
        out_ready = 1'b1;
        start_scan(4'd0, 4'd2);
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %0b, expected 0", out_valid); end
        tick();
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_latency: got %0b, expected 1", out_valid); end
        wait_done(20, cyc);
        n_checks += 3;
        if (cyc + 2 != 5) begin n_fail++; $display("FAIL basic_done_latency: got %0d cycles, expected 5", cyc + 2); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %0b, expected 0", busy); end
        if (sum !== sum_expect()) begin n_fail++; $display("FAIL basic_sum: got %0d, expected %0d", sum, sum_expect()); end
        tick();
        n_checks += 2;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, expected 1", done_cnt - d0); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_words_left: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        int cyc;
        out_ready = 1'b1;
        start_scan(4'd15, 4'd1);
        wait_done(20, cyc);
        tick();
        n_checks += 2;
        if (sum !== sum_expect()) begin n_fail++; $display("FAIL wrap_sum: got %0d, expected %0d", sum, sum_expect()); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_words_left: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        int cyc;
        out_ready = 1'b0;
        start_scan(4'd0, 4'd15);
        repeat (10) tick();
        n_checks += 4;
        if (rom_addr !== 4'd4) begin n_fail++; $display("FAIL stall_rom_addr: got %0d, expected 4", rom_addr); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b, expected 1", out_valid); end
        if ({out_addr, out_data} !== exp_q[0]) begin n_fail++; $display("FAIL stall_head: got %0h, expected %0h", {out_addr, out_data}, exp_q[0]); end
        if (exp_q.size() != 16) begin n_fail++; $display("FAIL stall_no_pop: got %0d pending, expected 16", exp_q.size()); end
        out_ready = 1'b1;
        wait_done(40, cyc);
        tick();
        n_checks += 2;
        if (sum !== sum_expect()) begin n_fail++; $display("FAIL stall_sum: got %0d, expected %0d", sum, sum_expect()); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_words_left: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_single_busy();
        int d0, cyc;
        d0        = done_cnt;
        out_ready = 1'b1;
        start_scan(4'd15, 4'd15);
        first_addr = 4'd3;
        last_addr  = 4'd5;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, cyc);
        n_checks += 2;
        if (cyc + 2 != 3) begin n_fail++; $display("FAIL single_done_latency: got %0d cycles, expected 3", cyc + 2); end
        if (sum !== sum_expect()) begin n_fail++; $display("FAIL single_sum: got %0d, expected %0d", sum, sum_expect()); end
        tick();
        n_checks += 1;
        if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %0b, expected 0", done); end
        repeat (4) tick();
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_ignored_start: got busy %0b, expected 0", busy); end
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL single_done_count: got %0d, expected 1", done_cnt - d0); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_words_left: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d0, guard;
        out_ready = 1'b1;
        start_scan(4'd0, 4'd15);
        guard = 0;
        while (rom_addr !== 4'd5 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks += 1;
        if (rom_addr !== 4'd5) begin n_fail++; $display("FAIL midrst_reach: got addr %0d, expected 5", rom_addr); end
        d0    = done_cnt;
        rst_n = 1'b0;
        tick();
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b, expected 0", out_valid); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %0b, expected 0", busy); end
        if (rom_addr !== 4'd0)  begin n_fail++; $display("FAIL midrst_rom_addr: got %0d, expected 0", rom_addr); end
        if (sum !== 9'd0)       begin n_fail++; $display("FAIL midrst_sum: got %0d, expected 0", sum); end
        rst_n = 1'b1;
        exp_q.delete();
        repeat (6) tick();
        n_checks += 2;
        if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_done: got %0d pulses, expected 0", done_cnt - d0); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: got valid %0b, expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_single_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
